// File: rtl/qdma_h2c_pkt_gen_pkg.sv
// Shared types and sizing helpers for the QDMA H2C packet generator.
//   state_e    : generator FSM states (idle, sending beats, inter-packet gap)
//   data_bytes : bytes per tdata beat for a given bus width
//   mty_width  : width of the empty-byte count for a given bus width
package qdma_h2c_pkt_gen_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StGap  = 2'd2
  } state_e;

  function automatic int unsigned data_bytes(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned mty_width(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/qdma_h2c_pkt_gen_if.sv
// AXI4-Stream H2C bus carrying generated packets plus QDMA tuser sidebands.
//   master : drives tvalid/tdata/tlast/tuser_*, samples tready
//   slave  : samples the payload, drives tready
interface qdma_h2c_pkt_gen_if
  import qdma_h2c_pkt_gen_pkg::*;
#(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned QID_W  = 11,
  parameter int unsigned MTY_W  = mty_width(DATA_W)
) ();

  logic              tvalid;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tready;
  logic [QID_W-1:0]  tuser_qid;
  logic [31:0]       tuser_mdata;
  logic [MTY_W-1:0]  tuser_mty;

  modport master (
    output tvalid, tdata, tlast, tuser_qid, tuser_mdata, tuser_mty,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tlast, tuser_qid, tuser_mdata, tuser_mty,
    output tready
  );

endinterface

// File: rtl/qdma_h2c_pkt_gen.sv
// QDMA H2C traffic generator. A cfg_start pulse latches the run configuration and emits
// cfg_num_pkt packets (0 = until cfg_stop) of cfg_pkt_len bytes, rotating the queue id over
// cfg_num_q queues from cfg_base_qid, with cfg_gap idle cycles between packets.
// Ports:
//   axis_aclk, axis_aresetn : clock, async active-low reset
//   cfg_*                   : run configuration and start/stop pulses
//   m_axis_h2c              : generated AXI-Stream packets (master side)
//   stat_busy/done/pkt_cnt  : run status, end-of-run pulse, packets sent this run
module qdma_h2c_pkt_gen
  import qdma_h2c_pkt_gen_pkg::*;
#(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned QID_W  = 11,
  parameter int unsigned MTY_W  = mty_width(DATA_W)
) (
  input  logic               axis_aclk,
  input  logic               axis_aresetn,
  input  logic               cfg_start,
  input  logic               cfg_stop,
  input  logic [15:0]        cfg_pkt_len,
  input  logic [31:0]        cfg_num_pkt,
  input  logic [QID_W-1:0]   cfg_base_qid,
  input  logic [QID_W-1:0]   cfg_num_q,
  input  logic [7:0]         cfg_gap,
  qdma_h2c_pkt_gen_if.master m_axis_h2c,
  output logic               stat_busy,
  output logic               stat_done,
  output logic [31:0]        stat_pkt_cnt
);

  localparam int unsigned DataBytes = data_bytes(DATA_W);
  localparam logic [16:0] BeatBytes = 17'(DataBytes);

  state_e           state_q;
  logic [15:0]      len_q;
  logic [31:0]      num_pkt_q;
  logic [QID_W-1:0] base_qid_q;
  logic [QID_W-1:0] num_q_q;
  logic [QID_W-1:0] qoff_q;
  logic [7:0]       gap_q;
  logic [7:0]       gap_cnt_q;
  logic [7:0]       beat_q;
  logic [16:0]      rem_q;     // bytes of the current packet not yet in an accepted beat
  logic [31:0]      pkt_idx_q;
  logic [31:0]      pkt_cnt_q;
  logic             stop_q;
  logic             done_q;

  logic        sending;
  logic        last_beat;
  logic [31:0] pkt_idx_nxt;
  logic        run_done;
  logic [7:0]  fill_byte;

  assign sending     = (state_q == StSend);
  assign last_beat   = (rem_q <= BeatBytes);
  assign pkt_idx_nxt = pkt_idx_q + 32'd1;
  // A stop arriving on the same cycle as the final beat still ends the run there.
  assign run_done    = stop_q || cfg_stop || ((num_pkt_q != 32'd0) && (pkt_idx_nxt == num_pkt_q));
  assign fill_byte   = pkt_idx_q[7:0] + beat_q;

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q    <= StIdle;
      len_q      <= '0;
      num_pkt_q  <= '0;
      base_qid_q <= '0;
      num_q_q    <= '0;
      qoff_q     <= '0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      beat_q     <= '0;
      rem_q      <= '0;
      pkt_idx_q  <= '0;
      pkt_cnt_q  <= '0;
      stop_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cfg_start && (cfg_pkt_len != 16'd0)) begin
            len_q      <= cfg_pkt_len;
            num_pkt_q  <= cfg_num_pkt;
            base_qid_q <= cfg_base_qid;
            num_q_q    <= (cfg_num_q == '0) ? QID_W'(1) : cfg_num_q;
            gap_q      <= cfg_gap;
            qoff_q     <= '0;
            beat_q     <= '0;
            rem_q      <= {1'b0, cfg_pkt_len};
            pkt_idx_q  <= '0;
            pkt_cnt_q  <= '0;
            stop_q     <= 1'b0;
            state_q    <= StSend;
          end
        end
        StSend: begin
          if (cfg_stop) stop_q <= 1'b1;
          if (m_axis_h2c.tready) begin
            if (last_beat) begin
              pkt_cnt_q <= pkt_cnt_q + 32'd1;
              pkt_idx_q <= pkt_idx_nxt;
              qoff_q    <= (qoff_q == num_q_q - QID_W'(1)) ? '0 : qoff_q + QID_W'(1);
              beat_q    <= '0;
              rem_q     <= {1'b0, len_q};
              if (run_done) begin
                state_q <= StIdle;
                done_q  <= 1'b1;
                stop_q  <= 1'b0;
              end else if (gap_q != 8'd0) begin
                state_q   <= StGap;
                gap_cnt_q <= gap_q;
              end
            end else begin
              beat_q <= beat_q + 8'd1;
              rem_q  <= rem_q - BeatBytes;
            end
          end
        end
        StGap: begin
          if (cfg_stop || stop_q) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
            stop_q  <= 1'b0;
          end else if (gap_cnt_q <= 8'd1) begin
            state_q <= StSend;
          end else begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Payload is a pure function of registered packet/beat state, so it holds across stalls.
  assign m_axis_h2c.tvalid      = sending;
  assign m_axis_h2c.tdata       = sending ? {DataBytes{fill_byte}} : '0;
  assign m_axis_h2c.tlast       = sending && last_beat;
  assign m_axis_h2c.tuser_mty   = (sending && last_beat) ? MTY_W'(BeatBytes - rem_q) : '0;
  assign m_axis_h2c.tuser_mdata = sending ? {16'b0, len_q} : '0;
  assign m_axis_h2c.tuser_qid   = sending ? (base_qid_q + qoff_q) : '0;

  assign stat_busy    = (state_q != StIdle);
  assign stat_done    = done_q;
  assign stat_pkt_cnt = pkt_cnt_q;

endmodule
